// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the cache/memory side of the CPU.
//   word_t          - 32-bit data/address word
//   ramstate_t      - RAM model handshake state
//   memctrl_state_t - cache_mem_ctrl FSM state
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DSRV = 2'd1,
    ISRV = 2'd2
  } memctrl_state_t;

endpackage

// File: rtl/arb_fair_cnt.sv
// arb_fair_cnt: starvation counter for the icache side of the memory arbiter.
// Counts data grants that completed while the icache was waiting and flags
// when the limit is reached so the next grant goes to the icache.
// Ports:
//   CLK, nRST  clock, asynchronous active-low reset
//   inc        a dcache service completed while iREN was high
//   clr        icache served, or icache not requesting while idle
//   starved    count has reached STARVE_MAX
module arb_fair_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic starved
);

  localparam int W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [W-1:0] CNT_MAX = W'(STARVE_MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign starved = (cnt == CNT_MAX);

endmodule

// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: memory-side responder for the dcache/icache bus. Arbitrates
// the two caches onto a single-ported RAM and returns wait/load responses.
// Optional feature macro: MEM_CTRL_STATS_EN (per-side transaction counters).
// Ports:
//   CLK, nRST                         clock, asynchronous active-low reset
//   dREN, dWEN, daddr, dstore         dcache request (held until dwait=0)
//   dwait, dload                      dcache response
//   iREN, iaddr                       icache request
//   iwait, iload                      icache response
//   ramREN, ramWEN, ramaddr, ramstore RAM request
//   ramload, ramstate                 RAM response
//   err_cnt                           saturating count of RAM ERROR cycles
//   d_txn_cnt, i_txn_cnt              completed transactions (0 without stats)
//
// state | meaning
// IDLE  | no RAM strobes, both waits high; arbitrate pending requests
// DSRV  | dcache granted, RAM driven from live dcache inputs
// ISRV  | icache granted, RAM driven from live icache inputs
module cache_mem_ctrl
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [7:0]  err_cnt,
  output logic [31:0] d_txn_cnt,
  output logic [31:0] i_txn_cnt
);

  memctrl_state_t state;
  ramstate_t      rs;
  logic           d_req;
  logic           d_live;
  logic           i_live;
  logic           d_done;
  logic           i_done;
  logic           err_hit;
  logic           starved;

  assign rs      = ramstate_t'(ramstate);
  assign d_req   = dREN | dWEN;
  // A "live" service state still has its requester asserting; otherwise the
  // request was abandoned and nothing may complete or count.
  assign d_live  = (state == DSRV) && d_req;
  assign i_live  = (state == ISRV) && iREN;
  assign d_done  = d_live && (rs == ACCESS);
  assign i_done  = i_live && (rs == ACCESS);
  assign err_hit = (d_live || i_live) && (rs == ERROR);

  arb_fair_cnt #(.STARVE_MAX(STARVE_MAX)) u_fair (
    .CLK     (CLK),
    .nRST    (nRST),
    .inc     (d_done && iREN),
    .clr     (i_done || ((state == IDLE) && !iREN)),
    .starved (starved)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && !(iREN && starved)) state <= DSRV;
          else if (iREN)                   state <= ISRV;
        end
        DSRV: if (!d_req || d_done) state <= IDLE;
        ISRV: if (!iREN || i_done)  state <= IDLE;
        default: state <= IDLE;
      endcase
      if (err_hit && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Strobes and loads follow the live requester inputs so an abandoned
  // request drops the RAM strobes in the same cycle.
  always_comb begin
    dwait    = 1'b1;
    iwait    = 1'b1;
    dload    = '0;
    iload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      DSRV: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        dwait    = ~d_done;
      end
      ISRV: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        iwait   = ~i_done;
      end
      default: ;
    endcase
  end

`ifdef MEM_CTRL_STATS_EN
  word_t d_cnt;
  word_t i_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      d_cnt <= '0;
      i_cnt <= '0;
    end else begin
      if (d_done) d_cnt <= d_cnt + 32'd1;
      if (i_done) i_cnt <= i_cnt + 32'd1;
    end
  end

  assign d_txn_cnt = d_cnt;
  assign i_txn_cnt = i_cnt;
`else
  assign d_txn_cnt = '0;
  assign i_txn_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_mem_ctrl.sv
module tb_cache_mem_ctrl;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dREN, dWEN, iREN;
  logic [31:0] daddr, dstore, iaddr, ramload;
  logic [1:0]  ramstate;
  logic        dwait, iwait, ramREN, ramWEN;
  logic [31:0] dload, iload, ramaddr, ramstore, d_txn_cnt, i_txn_cnt;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        side;   // 0 = dcache, 1 = icache
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

`ifdef MEM_CTRL_STATS_EN
  localparam logic [31:0] EXP_D_TXN = 32'd3;
  localparam logic [31:0] EXP_I_TXN = 32'd2;
`else
  localparam logic [31:0] EXP_D_TXN = 32'd0;
  localparam logic [31:0] EXP_I_TXN = 32'd0;
`endif

  cache_mem_ctrl #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .err_cnt(err_cnt), .d_txn_cnt(d_txn_cnt), .i_txn_cnt(i_txn_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitor: every completion must match the next expected entry.
  always @(negedge CLK) begin
    if (nRST === 1'b1 && (dwait !== 1'b1 || iwait !== 1'b1)) begin
      chk("waits_exclusive", {31'd0, dwait | iwait}, 32'd1);
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_completion: dwait %b iwait %b at %0t", dwait, iwait, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("cmp_side", {31'd0, iwait === 1'b0}, {31'd0, e.side});
        chk("cmp_load", e.side ? iload : dload, e.data);
        chk("cmp_other_load", e.side ? dload : iload, 32'd0);
      end
    end
  end

  // One 2-cycle transaction with ACCESS on the first service cycle.
  task automatic txn(input logic is_i, input logic we, input logic [31:0] addr,
                     input logic [31:0] store, input logic [31:0] rdata);
    if (is_i) begin
      iREN = 1'b1; iaddr = addr;
    end else begin
      dREN = ~we; dWEN = we; daddr = addr; dstore = store;
    end
    ramstate = ACCESS;
    ramload  = rdata;
    q.push_back('{is_i, rdata});
    @(negedge CLK);
    chk("grant_no_strobe", {30'd0, ramREN, ramWEN}, 32'd0);
    tick();
    @(negedge CLK);
    chk("svc_ren", {31'd0, ramREN}, {31'd0, ~we});
    chk("svc_wen", {31'd0, ramWEN}, {31'd0, we});
    chk("svc_addr", ramaddr, addr);
    if (we) chk("svc_store", ramstore, store);
    tick();
    dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    chk("bubble_strobe", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("bubble_waits", {30'd0, dwait, iwait}, 32'd3);
    tick();
  endtask

  initial begin
    nRST = 1'b0;
    dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
    daddr = '0; dstore = '0; iaddr = '0; ramload = '0;
    ramstate = FREE;
    #1;
    chk("rst_waits", {30'd0, dwait, iwait}, 32'd3);
    chk("rst_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("rst_loads", dload | iload, 32'd0);
    chk("rst_addr_store", ramaddr | ramstore, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("rst_txn_cnt", d_txn_cnt | i_txn_cnt, 32'd0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    tick();

    // Single dcache read, completes on cycle 2.
    txn(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);

    // dcache write with 3 BUSY cycles then ACCESS.
    dWEN = 1'b1; daddr = 32'h3100; dstore = 32'h5; ramload = 32'h5A5A5A5A;
    q.push_back('{1'b0, 32'h5A5A5A5A});
    for (int k = 1; k <= 5; k++) begin
      ramstate = (k == 5) ? ACCESS : BUSY;
      @(negedge CLK);
      chk("wr_ramwen", {31'd0, ramWEN}, {31'd0, k >= 2});
      chk("wr_ramren", {31'd0, ramREN}, 32'd0);
      chk("wr_iwait", {31'd0, iwait}, 32'd1);
      chk("wr_dwait", {31'd0, dwait}, {31'd0, k != 5});
      chk("wr_store", ramstore, (k >= 2) ? 32'h5 : 32'h0);
      tick();
    end
    dWEN = 1'b0; ramstate = FREE;

    // Both requesting continuously: D,D,D,D,I,D,D,D,D,I
    for (int n = 0; n < 10; n++)
      q.push_back('{(n % 5) == 4, 32'h1000 + 32'(2 * n + 2)});
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h10; iaddr = 32'h20; ramstate = ACCESS;
    for (int c = 1; c <= 20; c++) begin
      ramload = 32'h1000 + 32'(c);
      @(negedge CLK);
      if (iwait === 1'b0) chk("arb_iaddr", ramaddr, 32'h20);
      tick();
    end
    dREN = 1'b0; iREN = 1'b0; ramstate = FREE;

    // Two ERROR cycles then ACCESS.
    dREN = 1'b1; daddr = 32'h200; ramload = 32'hCAFEF00D;
    q.push_back('{1'b0, 32'hCAFEF00D});
    tick();
    ramstate = ERROR;
    @(negedge CLK); chk("err_dwait1", {31'd0, dwait}, 32'd1);
    tick();
    @(negedge CLK); chk("err_dwait2", {31'd0, dwait}, 32'd1);
    tick();
    ramstate = ACCESS;
    tick();
    dREN = 1'b0; ramstate = FREE;
    @(negedge CLK); chk("err_cnt_2", {24'd0, err_cnt}, 32'd2);
    tick();

    // 300 ERROR cycles saturate err_cnt at 255.
    dREN = 1'b1; daddr = 32'h204; ramstate = ERROR;
    tick();
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      chk("err_cnt_ramp", {24'd0, err_cnt}, (i + 2 > 255) ? 32'd255 : 32'(i + 2));
      tick();
    end
    ramstate = ACCESS; ramload = 32'h77;
    q.push_back('{1'b0, 32'h77});
    tick();
    dREN = 1'b0; ramstate = FREE;
    @(negedge CLK); chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
    tick();

    // Reset mid-service aborts the access.
    dWEN = 1'b1; daddr = 32'h40; dstore = 32'h99; ramstate = BUSY;
    tick();
    @(negedge CLK); chk("pre_rst_wen", {31'd0, ramWEN}, 32'd1);
    tick();
    nRST = 1'b0;
    #1;
    chk("mid_rst_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("mid_rst_dwait", {31'd0, dwait}, 32'd1);
    chk("mid_rst_addr", ramaddr | ramstore, 32'd0);
    chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    dWEN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    txn(1'b0, 1'b0, 32'h80, 32'h0, 32'h600D600D);

    // Abandoned request: strobes drop the same cycle, no completion.
    dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
    tick();
    @(negedge CLK); chk("abn_ren_on", {31'd0, ramREN}, 32'd1);
    tick();
    dREN = 1'b0;
    @(negedge CLK);
    chk("abn_strobes_off", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("abn_dwait", {31'd0, dwait}, 32'd1);
    tick();
    ramstate = ACCESS;
    @(negedge CLK);
    chk("abn_idle_waits", {30'd0, dwait, iwait}, 32'd3);
    chk("abn_err_cnt", {24'd0, err_cnt}, 32'd0);
    tick();

    // icache and dcache traffic for the stats counters.
    txn(1'b1, 1'b0, 32'h400, 32'h0, 32'h11110001);
    txn(1'b1, 1'b0, 32'h404, 32'h0, 32'h11110002);
    txn(1'b0, 1'b1, 32'h500, 32'hABCD, 32'h0);
    txn(1'b0, 1'b0, 32'h504, 32'h0, 32'h22220003);
    @(negedge CLK);
    chk("d_txn_cnt", d_txn_cnt, EXP_D_TXN);
    chk("i_txn_cnt", i_txn_cnt, EXP_I_TXN);
    chk("pending_completions", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
